// File: rtl/fetch_unit.sv
// fetch_unit: fetches one instruction at a time from instruction memory and presents it downstream
// until it is consumed, then advances the PC sequentially, jumps, or stops on halt.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd,
    input  logic [15:0]       imem_data,
    input  logic              imem_valid,
    input  logic              stall,
    input  logic              jump_taken,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              halt,
    output logic [3:0]        opcode,
    output logic [11:0]       operand,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic [15:0]       icount
);
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_ISSUE, S_HALTED} state_t;
    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;
    logic [15:0]       r_icount;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_icount <= '0;
        end else begin
            case (r_state)
                S_FETCH: r_state <= S_WAIT;
                S_WAIT: begin
                    if (imem_valid) begin
                        r_ir    <= imem_data;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        r_icount <= r_icount + 16'(r_icount != 16'hFFFF);
                        r_state  <= halt ? S_HALTED : S_FETCH;
                        if (!halt) r_pc <= jump_taken ? jump_target : r_pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
    // The read strobe is masked by reset so that no request leaves while reset is held.
    assign imem_rd     = r_state == S_FETCH && !reset;
    assign imem_addr   = r_pc;
    assign pc_out      = r_pc;
    assign opcode      = r_ir[15:12];
    assign operand     = r_ir[11:0];
    assign instr_valid = r_state == S_ISSUE;
    assign halted      = r_state == S_HALTED;
    assign icount      = r_icount;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a behavioural memory and a transaction-level model of
// PC, consume count, halt and instruction-valid, checked against the DUT every cycle.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic        stall;
    logic        jump_taken;
    logic [9:0]  jump_target;
    logic        halt;
    logic [3:0]  opcode;
    logic [11:0] operand;
    logic        instr_valid;
    logic [9:0]  pc_out;
    logic        halted;
    logic [15:0] icount;

    fetch_unit #(.ADDR_W(10), .RESET_PC(10'h000)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .imem_data(imem_data), .imem_valid(imem_valid), .stall(stall),
        .jump_taken(jump_taken), .jump_target(jump_target), .halt(halt),
        .opcode(opcode), .operand(operand), .instr_valid(instr_valid),
        .pc_out(pc_out), .halted(halted), .icount(icount)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [1024];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 0;
    logic [9:0]  m_pc = '0;
    logic [15:0] m_cnt = '0;
    logic        m_halt = 1'b0;
    logic        m_iv = 1'b0;
    logic        m_rd_due = 1'b0;
    bit          armed = 1'b0;
    logic [9:0]  rd_addr_q [$];
    int          rd_cyc_q [$];
    logic [15:0] cons_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_pc(input logic [9:0] pc, input bit need_valid, input string name);
        int n = 0;
        bit ok;
        do begin
            @(negedge clk);
            n++;
            ok = (pc_out === pc) && (!need_valid || instr_valid === 1'b1);
        end while (!ok && n < 200);
        chk({"reach ", name}, 32'(ok), 32'd1);
    endtask

    // Memory: answers a read after lat extra wait cycles, forgets requests on reset.
    initial begin
        bit         pend = 1'b0;
        int         wt = 0;
        logic [9:0] paddr = '0;
        imem_valid = 1'b0;
        imem_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) pend = 1'b0;
            else if (imem_rd) begin
                pend  = 1'b1;
                wt    = lat;
                paddr = imem_addr;
            end
            @(posedge clk);
            #1;
            imem_valid = 1'b0;
            if (pend) begin
                if (wt == 0) begin
                    imem_valid = 1'b1;
                    imem_data  = mem[paddr];
                    pend       = 1'b0;
                end else wt--;
            end
        end
    end

    // Model: what has been consumed decides PC/count/halt; a read is due the cycle after reset
    // releases or after a non-halt consume; the instruction becomes valid the cycle after memory answers.
    always @(negedge clk) begin
        cyc++;
        if (armed) begin
            chk("pc_out", 32'(pc_out), 32'(m_pc));
            chk("icount", 32'(icount), 32'(m_cnt));
            chk("halted", 32'(halted), 32'(m_halt));
            chk("instr_valid", 32'(instr_valid), 32'(m_iv));
            chk("imem_rd", 32'(imem_rd), 32'(m_rd_due && !reset));
            if (imem_rd) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
            if (m_iv && instr_valid) chk("instr", 32'({opcode, operand}), 32'(mem[m_pc]));
        end
        if (imem_rd === 1'b1) begin
            rd_addr_q.push_back(imem_addr);
            rd_cyc_q.push_back(cyc);
        end
        if (reset) begin
            m_pc     = 10'h000;
            m_cnt    = '0;
            m_halt   = 1'b0;
            m_iv     = 1'b0;
            m_rd_due = 1'b1;
            armed    = 1'b1;
        end else begin
            m_rd_due = 1'b0;
            if (m_iv && !stall) begin
                cons_q.push_back({opcode, operand});
                m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
                m_iv  = 1'b0;
                if (halt) m_halt = 1'b1;
                else begin
                    m_pc     = jump_taken ? jump_target : m_pc + 10'd1;
                    m_rd_due = 1'b1;
                end
            end else if (imem_valid && !m_halt) m_iv = 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b1; stall = 1'b0; jump_taken = 1'b0; jump_target = '0; halt = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 40503 + 7);
        mem[0] = 16'h3123; mem[1] = 16'h4456; mem[2] = 16'h5FF1; mem[5] = 16'h7ABC;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rst imem_rd", 32'(imem_rd), 32'd0);
        chk("rst imem_addr", 32'(imem_addr), 32'h000);
        chk("rst pc_out", 32'(pc_out), 32'h000);
        chk("rst opcode", 32'(opcode), 32'd0);
        chk("rst operand", 32'(operand), 32'd0);
        chk("rst instr_valid", 32'(instr_valid), 32'd0);
        chk("rst halted", 32'(halted), 32'd0);
        chk("rst icount", 32'(icount), 32'd0);
        @(posedge clk); #1; reset = 1'b0;
        // Three zero-wait sequential instructions
        wait_pc(10'd3, 1'b0, "pc3");
        chk("seq icount", 32'(icount), 32'd3);
        chk("seq rd0 addr", 32'(rd_addr_q[0]), 32'h000);
        chk("seq rd1 addr", 32'(rd_addr_q[1]), 32'h001);
        chk("seq rd2 addr", 32'(rd_addr_q[2]), 32'h002);
        chk("seq rd spacing 1", 32'(rd_cyc_q[1] - rd_cyc_q[0]), 32'd3);
        chk("seq rd spacing 2", 32'(rd_cyc_q[2] - rd_cyc_q[1]), 32'd3);
        chk("seq instr0", 32'(cons_q[0]), 32'h3123);
        chk("seq instr1", 32'(cons_q[1]), 32'h4456);
        chk("seq instr2", 32'(cons_q[2]), 32'h5FF1);
        // Stall four cycles on PC 5
        wait_pc(10'd5, 1'b0, "pc5");
        @(posedge clk); #1; stall = 1'b1;
        wait_pc(10'd5, 1'b1, "iss5");
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            chk("stall opcode", 32'(opcode), 32'h7);
            chk("stall operand", 32'(operand), 32'hABC);
            chk("stall pc_out", 32'(pc_out), 32'h005);
            chk("stall valid", 32'(instr_valid), 32'd1);
        end
        @(posedge clk); #1; stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("after stall rd", 32'(imem_rd), 32'd1);
        chk("after stall addr", 32'(imem_addr), 32'h006);
        // Jump during stall is ignored, jump on consume redirects
        @(posedge clk); #1; stall = 1'b1; jump_taken = 1'b1; jump_target = 10'h155;
        wait_pc(10'd6, 1'b1, "iss6");
        repeat (2) @(negedge clk);
        chk("jump in stall pc", 32'(pc_out), 32'h006);
        @(posedge clk); #1; jump_target = 10'h2A0; stall = 1'b0;
        @(negedge clk);
        @(posedge clk); #1; stall = 1'b1; jump_taken = 1'b0;
        @(negedge clk);
        chk("jump rd", 32'(imem_rd), 32'd1);
        chk("jump addr", 32'(imem_addr), 32'h2A0);
        // PC wrap from 0x3FF
        wait_pc(10'h2A0, 1'b1, "iss2A0");
        @(posedge clk); #1; stall = 1'b0; jump_taken = 1'b1; jump_target = 10'h3FF;
        @(negedge clk);
        @(posedge clk); #1; stall = 1'b1; jump_taken = 1'b0;
        wait_pc(10'h3FF, 1'b1, "iss3FF");
        @(posedge clk); #1; stall = 1'b0;
        @(negedge clk);
        @(posedge clk); #1; stall = 1'b1;
        @(negedge clk);
        chk("wrap rd", 32'(imem_rd), 32'd1);
        chk("wrap addr", 32'(imem_addr), 32'h000);
        // Count saturation, starting just below the ceiling
        wait_pc(10'h000, 1'b1, "iss0");
        @(posedge clk); #1; dut.r_icount = 16'hFFFE; m_cnt = 16'hFFFE; stall = 1'b0;
        wait_pc(10'd2, 1'b0, "pc2");
        chk("sat icount", 32'(icount), 32'hFFFF);
        @(posedge clk); #1; stall = 1'b1;
        // Halt together with jump
        wait_pc(10'd2, 1'b1, "iss2");
        @(posedge clk); #1; stall = 1'b0; halt = 1'b1; jump_taken = 1'b1; jump_target = 10'h100;
        @(negedge clk);
        @(posedge clk); #1; halt = 1'b0; jump_taken = 1'b0;
        n = rd_addr_q.size();
        @(negedge clk);
        chk("halt halted", 32'(halted), 32'd1);
        chk("halt valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            stall = i[0]; halt = i[1]; jump_taken = i[2]; jump_target = 10'h0F0;
            @(negedge clk);
        end
        chk("halt no rd", 32'(rd_addr_q.size()), 32'(n));
        chk("halt pc held", 32'(pc_out), 32'h002);
        // Reset in WAIT with a three-cycle memory latency
        @(posedge clk); #1; lat = 3; stall = 1'b0; halt = 1'b0; jump_taken = 1'b0; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        wait_pc(10'h000, 1'b1, "lat iss0");
        chk("lat instr0", 32'({opcode, operand}), 32'h3123);
        wait_pc(10'd1, 1'b0, "lat pc1");
        @(posedge clk); #1;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk("mid rst pc_out", 32'(pc_out), 32'h000);
        chk("mid rst icount", 32'(icount), 32'd0);
        chk("mid rst valid", 32'(instr_valid), 32'd0);
        chk("mid rst halted", 32'(halted), 32'd0);
        chk("mid rst opcode", 32'(opcode), 32'd0);
        chk("mid rst operand", 32'(operand), 32'd0);
        chk("mid rst rd", 32'(imem_rd), 32'd1);
        chk("mid rst addr", 32'(imem_addr), 32'h000);
        wait_pc(10'h000, 1'b1, "post rst iss0");
        chk("post rst instr", 32'({opcode, operand}), 32'h3123);
        repeat (8) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
